// File: rtl/input_event_debouncer_if.sv
// Button/event bundle for input_event_debouncer.
// master: the debouncer (drives levels, pulses and the head of the event FIFO).
// slave : the consumer/board side (drives raw buttons and the pop strobe).
interface input_event_debouncer_if #(
    parameter int unsigned NUM_CH  = 13,
    parameter int unsigned CH_W    = 4,
    parameter int unsigned FIFO_AW = 3
) ();
    logic [NUM_CH-1:0]  btn_in;
    logic [NUM_CH-1:0]  btn_level;
    logic [NUM_CH-1:0]  btn_rise;
    logic [NUM_CH-1:0]  btn_fall;
    logic               evt_valid;
    logic [CH_W-1:0]    evt_ch;
    logic               evt_pressed;
    logic               evt_ready;
    logic [FIFO_AW:0]   evt_count;
    logic               evt_overflow;

    modport master (
        input  btn_in, evt_ready,
        output btn_level, btn_rise, btn_fall,
               evt_valid, evt_ch, evt_pressed, evt_count, evt_overflow
    );

    modport slave (
        output btn_in, evt_ready,
        input  btn_level, btn_rise, btn_fall,
               evt_valid, evt_ch, evt_pressed, evt_count, evt_overflow
    );
endinterface

// File: rtl/input_event_debouncer.sv
// Multi-channel button conditioner: 2-flop sync, stable-count debounce,
// rise/fall pulses, and a FWFT event FIFO of {channel, pressed} level changes.
// Optional auto-repeat of held presses: define INPUT_EVT_AUTO_REPEAT_EN.
module input_event_debouncer #(
    parameter int unsigned NUM_CH        = 13,
    parameter int unsigned CH_W          = 4,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned STABLE_CNT    = 500000,
    parameter int unsigned FIFO_AW       = 3,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input_event_debouncer_if.master    bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned EW    = CH_W + 1;

    logic [NUM_CH-1:0]  r_s1, r_s2, r_level, r_rise, r_fall;
    logic [CNT_W-1:0]   r_cnt [NUM_CH];
    logic [NUM_CH-1:0]  r_pend, r_pdir;
    logic               r_ovf;

    logic [EW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr, r_rd;
    logic [FIFO_AW:0]   r_count;

    logic [NUM_CH-1:0]  w_chg, w_rep, w_set, w_set_dir;
    logic               w_pop, w_push, w_any, w_valid;
    logic [CH_W-1:0]    w_idx;
    logic [EW-1:0]      w_head;

    // Accept a change once the synchronised input has differed for STABLE_CNT cycles
    always_comb begin
        w_chg = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            w_chg[i] = (r_s2[i] != r_level[i]) && (r_cnt[i] == CNT_W'(STABLE_CNT - 1));
    end

    // Synchroniser, debounce counters, debounced level and edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            r_s1   <= bus.btn_in;
            r_s2   <= r_s1;
            r_rise <= '0;
            r_fall <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (r_s2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_chg[i]) begin
                    r_cnt[i]   <= '0;
                    r_level[i] <= r_s2[i];
                    r_rise[i]  <= r_s2[i];
                    r_fall[i]  <= ~r_s2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef INPUT_EVT_AUTO_REPEAT_EN
    logic [31:0]       r_hold [NUM_CH];
    logic [NUM_CH-1:0] r_started;

    // Synthetic press after REPEAT_DELAY held cycles, then every REPEAT_PERIOD
    always_comb begin
        w_rep = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            w_rep[i] = r_level[i] && !w_chg[i] &&
                       (r_started[i] ? (r_hold[i] == REPEAT_PERIOD - 1)
                                     : (r_hold[i] == REPEAT_DELAY - 1));
    end

    // Hold counters restart on every accepted change and idle while released
    always_ff @(posedge clk) begin
        if (rst) begin
            r_started <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) r_hold[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_chg[i] || !r_level[i]) begin
                    r_hold[i]    <= '0;
                    r_started[i] <= 1'b0;
                end else if (w_rep[i]) begin
                    r_hold[i]    <= '0;
                    r_started[i] <= 1'b1;
                end else begin
                    r_hold[i] <= r_hold[i] + 32'd1;
                end
            end
        end
    end
`else
    assign w_rep = '0;
`endif

    // Pend sources, lowest-index push arbitration and FIFO handshake
    always_comb begin
        w_set     = w_chg | w_rep;
        w_set_dir = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            w_set_dir[i] = w_chg[i] ? r_s2[i] : 1'b1;
        w_any = 1'b0;
        w_idx = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (r_pend[i-1]) begin
                w_any = 1'b1;
                w_idx = CH_W'(i - 1);
            end
        end
        w_valid = (r_count != '0);
        w_pop   = w_valid && bus.evt_ready;
        w_push  = w_any && ((r_count != (FIFO_AW+1)'(DEPTH)) || w_pop);
    end

    // Pending bits: a new change beats the push clear; overwriting an unpushed event is an overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_pdir <= '0;
            r_ovf  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_set[i]) begin
                    r_pend[i] <= 1'b1;
                    r_pdir[i] <= w_set_dir[i];
                    if (r_pend[i] && !(w_push && (w_idx == CH_W'(i))))
                        r_ovf <= 1'b1;
                end else if (w_push && (w_idx == CH_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // FIFO storage (contents need no reset; the head is masked while empty)
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {w_idx, r_pdir[w_idx]};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + FIFO_AW'(1);
            if (w_pop)  r_rd <= r_rd + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head           = r_mem[r_rd];
    assign bus.btn_level    = r_level;
    assign bus.btn_rise     = r_rise;
    assign bus.btn_fall     = r_fall;
    assign bus.evt_valid    = w_valid;
    assign bus.evt_ch       = w_valid ? w_head[EW-1:1] : '0;
    assign bus.evt_pressed  = w_valid & w_head[0];
    assign bus.evt_count    = r_count;
    assign bus.evt_overflow = r_ovf;
endmodule

// File: tb/tb_input_event_debouncer.sv
// Scoreboard bench for input_event_debouncer (STABLE_CNT=4, FIFO depth 4).
// With INPUT_EVT_AUTO_REPEAT_EN defined it runs the auto-repeat scenario.
module tb_input_event_debouncer;
    localparam int unsigned NUM_CH = 13;
    localparam int unsigned CH_W   = 4;
    localparam int unsigned AW     = 2;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            pr;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    evt_t sb[$];

    always #5 clk = ~clk;

    input_event_debouncer_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .FIFO_AW(AW)) bus ();

    input_event_debouncer #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(20), .STABLE_CNT(4), .FIFO_AW(AW),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int ch, input logic v, input logic expect_evt);
        evt_t e;
        bus.btn_in[ch] = v;
        if (expect_evt) begin
            e.ch = CH_W'(ch);
            e.pr = v;
            sb.push_back(e);
        end
    endtask

    // Compare the head event with the scoreboard, then pop it
    task automatic pop_one(input string tag);
        evt_t e;
        check({tag, "_valid"}, bus.evt_valid, 1);
        if (bus.evt_valid && sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_ch"}, bus.evt_ch, e.ch);
            check({tag, "_pressed"}, bus.evt_pressed, e.pr);
        end
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        while (sb.size() != 0) begin
            w = 0;
            while (!bus.evt_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!bus.evt_valid) begin
                check({tag, "_timeout"}, bus.evt_valid, 1);
                sb.delete();
            end else begin
                pop_one(tag);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.btn_in    = '0;
        bus.evt_ready = 1'b0;
        cycles(3);
        check("rst_level", bus.btn_level, 0);
        check("rst_rise", bus.btn_rise, 0);
        check("rst_fall", bus.btn_fall, 0);
        check("rst_valid", bus.evt_valid, 0);
        check("rst_count", bus.evt_count, 0);
        check("rst_ovf", bus.evt_overflow, 0);
        rst = 1'b0;
        cycles(2);

`ifdef INPUT_EVT_AUTO_REPEAT_EN
        begin
            int t_exp[6] = '{1, 11, 15, 19, 23, 27};
            int t_got[$];
            int n_rise = 0;
            int w = 0;
            bus.btn_in[1] = 1'b1;
            while (!bus.btn_level[1] && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("rep_latency", w, 6);
            check("rep_rise0", bus.btn_rise[1], 1);
            bus.evt_ready = 1'b1;
            for (int t = 1; t <= 28; t++) begin
                @(negedge clk);
                if (bus.btn_rise[1]) n_rise++;
                if (bus.evt_valid) begin
                    t_got.push_back(t);
                    check("rep_ch", bus.evt_ch, 1);
                    check("rep_pressed", bus.evt_pressed, 1);
                end
            end
            check("rep_extra_rise", n_rise, 0);
            check("rep_n_events", t_got.size(), 6);
            for (int k = 0; k < 6 && k < t_got.size(); k++)
                check("rep_time", t_got[k], t_exp[k]);
            bus.btn_in[1] = 1'b0;
            cycles(20);
            bus.evt_ready = 1'b0;
            cycles(1);
            check("rep_rel_level", bus.btn_level[1], 0);
            check("rep_rel_count", bus.evt_count, 0);
        end
`else
        // Single press: level and rise exactly 6 cycles after the input edge
        drive(3, 1'b1, 1'b1);
        cycles(5);
        check("press_level_early", bus.btn_level[3], 0);
        cycles(1);
        check("press_level", bus.btn_level[3], 1);
        check("press_rise", bus.btn_rise[3], 1);
        check("press_count0", bus.evt_count, 0);
        cycles(1);
        check("press_rise_off", bus.btn_rise[3], 0);
        check("press_count1", bus.evt_count, 1);
        pop_one("press_pop");
        check("press_empty", bus.evt_valid, 0);
        check("press_count_e", bus.evt_count, 0);

        // Release: fall pulse with the same latency
        drive(3, 1'b0, 1'b1);
        cycles(5);
        check("rel_level_early", bus.btn_level[3], 1);
        cycles(1);
        check("rel_level", bus.btn_level[3], 0);
        check("rel_fall", bus.btn_fall[3], 1);
        cycles(1);
        check("rel_fall_off", bus.btn_fall[3], 0);
        drain("rel");

        // Glitch of 3 cycles is filtered
        bus.btn_in[0] = 1'b1;
        cycles(3);
        bus.btn_in[0] = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bus.btn_level[0] || bus.btn_rise[0] || bus.btn_fall[0] || bus.evt_valid) seen++;
            end
            check("glitch", seen, 0);
        end

        // Simultaneous rises queue lowest channel first
        drive(5, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b1);
        begin
            evt_t e;
            e.ch = 4'd5;
            e.pr = 1'b1;
            sb.push_back(e);
        end
        cycles(8);
        check("simul_count", bus.evt_count, 2);
        pop_one("simul_a");
        pop_one("simul_b");
        drive(2, 1'b0, 1'b1);
        drive(5, 1'b0, 1'b1);
        drain("simul_rel");

        // Full FIFO: fifth event waits, enters on the pop that frees a slot
        drive(4, 1'b1, 1'b1);
        drive(6, 1'b1, 1'b1);
        drive(8, 1'b1, 1'b1);
        drive(9, 1'b1, 1'b1);
        drive(10, 1'b1, 1'b1);
        cycles(12);
        check("full_count", bus.evt_count, 4);
        check("full_ovf", bus.evt_overflow, 0);
        pop_one("full_pop");
        check("full_refill", bus.evt_count, 4);
        check("full_ovf2", bus.evt_overflow, 0);
        drain("full");
        drive(4, 1'b0, 1'b1);
        drive(6, 1'b0, 1'b1);
        drive(8, 1'b0, 1'b1);
        drive(9, 1'b0, 1'b1);
        drive(10, 1'b0, 1'b1);
        drain("full_rel");

        // Overflow: press then release ch7 while its event is stuck pending
        drive(4, 1'b1, 1'b1);
        drive(6, 1'b1, 1'b1);
        drive(8, 1'b1, 1'b1);
        drive(9, 1'b1, 1'b1);
        cycles(12);
        check("ovf_full", bus.evt_count, 4);
        drive(7, 1'b1, 1'b0);
        cycles(8);
        check("ovf_not_yet", bus.evt_overflow, 0);
        drive(7, 1'b0, 1'b1);
        cycles(8);
        check("ovf_set", bus.evt_overflow, 1);
        drain("ovf");
        check("ovf_held", bus.evt_overflow, 1);

        // Reset mid-operation clears queued events and overflow
        bus.btn_in[11] = 1'b1;
        cycles(8);
        check("rst_pre_count", bus.evt_count, 1);
        bus.btn_in = '0;
        rst = 1'b1;
        cycles(1);
        check("rst2_level", bus.btn_level, 0);
        check("rst2_valid", bus.evt_valid, 0);
        check("rst2_count", bus.evt_count, 0);
        check("rst2_ovf", bus.evt_overflow, 0);
        check("rst2_ch", bus.evt_ch, 0);
        rst = 1'b0;
        sb.delete();
        cycles(10);
        check("post_rst_level", bus.btn_level, 0);
        check("post_rst_count", bus.evt_count, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/input_event_debouncer.md
Name: input_event_debouncer

Overview:
- Parametrised successor to the per-button Debouncer instances in the top level: one block conditions all NUM_CH player/control inputs.
- Per channel: 2-flop synchroniser, stable-count debounce, registered level, 1-cycle rise/fall pulses.
- All level changes are serialised into a first-word-fall-through event FIFO for vga_display game logic (combo/move detection).

Parameters:
- NUM_CH, 13, number of input channels (12 player buttons + knock_out).
- CH_W, 4, channel index width; must satisfy 2^CH_W >= NUM_CH.
- CNT_W, 20, debounce counter width.
- STABLE_CNT, 500000, cycles an input must stay stable before it is accepted (10 ms at 50 MHz); 2 <= STABLE_CNT < 2^CNT_W.
- FIFO_AW, 3, event FIFO address width; depth = 2^FIFO_AW.
- REPEAT_DELAY, 25000000, cycles held before first repeat (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between repeats (used only with AUTO_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  NUM_CH  raw asynchronous button inputs, active-high.
- btn_level  out  NUM_CH  debounced levels.
- btn_rise  out  NUM_CH  1-cycle pulse on an accepted 0->1 change.
- btn_fall  out  NUM_CH  1-cycle pulse on an accepted 1->0 change.
- evt_valid  out  1  FIFO non-empty.
- evt_ch  out  CH_W  channel index of the head event.
- evt_pressed  out  1  head event is a press (1) or a release (0).
- evt_ready  in  1  consumer pop; a pop occurs when evt_valid && evt_ready.
- evt_count  out  FIFO_AW+1  current FIFO occupancy.
- evt_overflow  out  1  sticky flag: an event was lost; cleared only by rst.

Behaviour:
- Reset state: all outputs 0, synchronisers 0, counters 0, pending bits 0, FIFO empty.
- Synchroniser: s1 <= btn_in; s2 <= s1.
- Debounce, per channel:
  - s2 == btn_level: counter cleared to 0.
  - Otherwise: counter increments.
  - When counter == STABLE_CNT-1 and s2 != btn_level: btn_level <= s2, counter cleared, matching rise/fall pulse asserted in the same cycle btn_level changes.
  - Glitch shorter than STABLE_CNT cycles: no change.
  - Latency from btn_in edge to btn_level change: exactly STABLE_CNT+2 cycles.
- Event capture, per channel:
  - A level change sets pend[i]=1 and pdir[i]=new level.
  - A change on a channel whose pend[i] is already 1 overwrites pdir[i] and sets evt_overflow.
- Push arbiter:
  - Each cycle, the lowest-indexed set pend bit is pushed {ch, pdir} if the FIFO can accept it; that pend bit clears.
  - At most one push per cycle.
  - If a channel changes in the same cycle its pend bit is being cleared by a push, the new change re-sets pend (no loss, no overflow).
- FIFO:
  - FWFT: evt_ch/evt_pressed are valid whenever evt_valid=1.
  - Push accepted when count < depth, or count == depth and a pop occurs in the same cycle.
  - Simultaneous push+pop leaves count unchanged.
  - Pop on empty is ignored.
  - Pointers wrap modulo depth.
  - Full with pending bits set: bits wait; overflow is set only by the overwrite rule.
- rst mid-operation: all state cleared next edge, including queued events and overflow.

Optional Feature:
- Macro: INPUT_EVT_AUTO_REPEAT_EN.
- Defined:
  - Per-channel hold counter starts on an accepted press.
  - After REPEAT_DELAY cycles of continuous btn_level=1, and every REPEAT_PERIOD cycles thereafter, pend[i]=1 and pdir[i]=1 are set (a synthetic press).
  - btn_rise is not pulsed for repeats.
  - Release clears the hold counter.
  - Repeat onto an already-set pend follows the overwrite rule.
- Undefined: no hold counters, no repeat events; REPEAT_* parameters are ignored.

Test Plan (sim with STABLE_CNT=4, FIFO_AW=2, NUM_CH=13):
- Single press: btn_in[3] 0->1 held → btn_level[3]=1 and btn_rise[3]=1 for one cycle exactly 6 cycles later; event {ch=3, pressed=1} visible next cycle with evt_count=1; pop → evt_valid=0.
- Glitch: btn_in[0] high for 3 cycles then low → btn_level, pulses and FIFO unchanged.
- Simultaneous: btn_in[5] and btn_in[2] rise on the same cycle, evt_ready=0 → events queued in order ch2 then ch5, evt_count=2.
- Full FIFO: evt_ready=0, 5 distinct presses → count saturates at 4, fifth stays pending; one pop → fifth pushed, count back to 4, evt_overflow=0.
- Overflow: FIFO full, press then release ch7 while its pend is set → evt_overflow=1 and held after drain; the drained ch7 event shows pressed=0. Assert rst → all outputs 0, evt_overflow=0.
- INPUT_EVT_AUTO_REPEAT_EN with REPEAT_DELAY=10, REPEAT_PERIOD=4: hold btn_in[1] for 30 cycles after acceptance → 1 real press + repeats at +10, +14, +18, +22, +26; btn_rise pulses once.
